// File: rtl/fp_unit_arbiter_if.sv
// Requester-side handshake and functional-unit bus shared by fp_unit_arbiter and its environment.
interface fp_unit_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic                    fu_in_valid;
  logic [DATA_W-1:0]       fu_a;
  logic [DATA_W-1:0]       fu_b;
  logic [DATA_W-1:0]       fu_z;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    busy;

  modport master (
    output req_valid, req_a, req_b, fu_z,
    input  req_ready, fu_in_valid, fu_a, fu_b, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, fu_z,
    output req_ready, fu_in_valid, fu_a, fu_b, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fp_unit_arbiter.sv
// Shares one fixed-latency FP unit among N_REQ requesters and steers results back to their owners.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module fp_unit_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input logic              clk,
  input logic              rst_n,
  fp_unit_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  logic              found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
`ifndef ARB_FIXED_PRIO_EN
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W:0]    sum;
`endif

  logic [LAT:0]      vld_p;
  logic [PTR_W-1:0]  own_p [0:LAT];
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [N_REQ-1:0]  rsp_vld;
  logic [DATA_W-1:0] rsp_data_q;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifndef ARB_FIXED_PRIO_EN
    sum     = '0;
`endif
    for (int j = 0; j < N_REQ; j++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = PTR_W'(j);
`else
      sum = {1'b0, ptr} + (PTR_W+1)'(j);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      cand = sum[PTR_W-1:0];
`endif
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    // No grant may be offered while the block is held in reset.
    found = found & rst_n;
  end

  // Stage p0: operand capture and tag entry; later stages track owners until fu_z lines up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p      <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      rsp_vld    <= '0;
      rsp_data_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      vld_p[0] <= found;
      for (int s = 1; s <= LAT; s++) vld_p[s] <= vld_p[s-1];
      if (found) begin
        a_p0 <= bus.req_a[gnt_idx*DATA_W +: DATA_W];
        b_p0 <= bus.req_b[gnt_idx*DATA_W +: DATA_W];
`ifndef ARB_FIXED_PRIO_EN
        ptr  <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
`endif
      end
      // Response stage: result from the unit returns to the owner recorded at issue.
      if (vld_p[LAT]) begin
        rsp_vld    <= onehot(own_p[LAT]);
        rsp_data_q <= bus.fu_z;
      end else begin
        rsp_vld    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    own_p[0] <= gnt_idx;
    for (int s = 1; s <= LAT; s++) own_p[s] <= own_p[s-1];
  end

  assign bus.req_ready   = found ? onehot(gnt_idx) : '0;
  assign bus.fu_in_valid = vld_p[0];
  assign bus.fu_a        = a_p0;
  assign bus.fu_b        = b_p0;
  assign bus.rsp_valid   = rsp_vld;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = (|vld_p) | (|rsp_vld);
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Self-checking bench for fp_unit_arbiter: vector table, directed corner sequences and random traffic.
module tb_fp_unit_arbiter;
  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int NVEC   = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_unit_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  fp_unit_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // IEEE single add through double-precision reals (normal operands only).
  function automatic logic [63:0] s2d(input logic [31:0] a);
    logic [10:0] e;
    if (a[30:0] == 31'd0) return {a[31], 63'd0};
    e = {3'b000, a[30:23]} + 11'd896;
    return {a[31], e, a[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real         s;
    logic [63:0] d;
    logic [10:0] e;
    s = $bitstoreal(s2d(a)) + $bitstoreal(s2d(b));
    if (s == 0.0) return 32'd0;
    d = $realtobits(s);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    e = 8'(120 + $urandom_range(0, 15));
    return {1'b0, e, 23'($urandom)};
  endfunction

  // Fully pipelined FP adder standing in for the shared unit.
  logic [DATA_W-1:0] fu_pipe [LAT];
  always @(posedge clk) begin
    fu_pipe[0] <= fadd(bus.fu_a, bus.fu_b);
    for (int s = 1; s < LAT; s++) fu_pipe[s] <= fu_pipe[s-1];
  end
  assign bus.fu_z = fu_pipe[LAT-1];

  // Reference model: grant search, expected-response queue in accept order.
  typedef struct {
    int          owner;
    logic [31:0] res;
    int          rsp_cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e_new;
  int          cyc = 0;
  int          m_ptr = 0;
  int          g;
  logic        m_fu_vld = 1'b0;
  logic [31:0] m_fu_a = '0, m_fu_b = '0, m_rsp_data = '0;

  function automatic int model_grant(input logic [N_REQ-1:0] rv, input int p);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (rv[i]) return i;
`else
    for (int j = 0; j < N_REQ; j++) if (rv[(p + j) % N_REQ]) return (p + j) % N_REQ;
`endif
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ptr = 0; m_fu_vld = 1'b0; m_fu_a = '0; m_fu_b = '0; m_rsp_data = '0;
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_fu_in_valid", bus.fu_in_valid, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
    end else begin
      cyc++;
      chk("busy", bus.busy, q.size() != 0);
      chk("fu_in_valid", bus.fu_in_valid, m_fu_vld);
      chk("fu_a", bus.fu_a, m_fu_a);
      chk("fu_b", bus.fu_b, m_fu_b);
      if (q.size() != 0 && q[0].rsp_cyc == cyc) begin
        chk("rsp_valid", bus.rsp_valid, 64'd1 << q[0].owner);
        m_rsp_data = q[0].res;
        chk("rsp_data", bus.rsp_data, m_rsp_data);
        void'(q.pop_front());
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 0);
        chk("rsp_data_hold", bus.rsp_data, m_rsp_data);
      end
      g = model_grant(bus.req_valid, m_ptr);
      chk("req_ready", bus.req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
      m_fu_vld = (g >= 0);
      if (g >= 0) begin
        m_fu_a        = bus.req_a[g*DATA_W +: DATA_W];
        m_fu_b        = bus.req_b[g*DATA_W +: DATA_W];
        e_new.owner   = g;
        e_new.res     = fadd(m_fu_a, m_fu_b);
        e_new.rsp_cyc = cyc + 2 + LAT;
        q.push_back(e_new);
        m_ptr = (g + 1) % N_REQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*DATA_W +: DATA_W] = rnd_f();
      bus.req_b[i*DATA_W +: DATA_W] = rnd_f();
    end
  endtask

  typedef struct {
    logic [N_REQ-1:0] rv;
    logic [N_REQ-1:0] exp_ready;
  } vec_t;

  localparam logic [N_REQ-1:0] RV [NVEC] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000,
                                             3'b010, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b000};
`ifdef ARB_FIXED_PRIO_EN
  localparam logic [N_REQ-1:0] EX [NVEC] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                                             3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
`else
  localparam logic [N_REQ-1:0] EX [NVEC] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000,
                                             3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b000};
`endif

  vec_t tbl [NVEC];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d0, d1, d3;
    for (int i = 0; i < NVEC; i++) tbl[i] = '{RV[i], EX[i]};
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      bus.req_valid = tbl[i].rv;
      rand_ops();
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].exp_ready);
      step();
    end
    bus.req_valid = '0;
    repeat (8) step();

    // Single request: 2.0 + 1.0 returns to requester 0 four cycles after accept.
    bus.req_valid = 3'b001;
    bus.req_a[31:0] = 32'h4000_0000;
    bus.req_b[31:0] = 32'h3F80_0000;
    @(negedge clk);
    chk("single_ready", bus.req_ready, 3'b001);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_fu_vld", bus.fu_in_valid, 1);
    chk("single_fu_a", bus.fu_a, 32'h4000_0000);
    repeat (3) step();
    @(negedge clk);
    chk("single_rsp_valid", bus.rsp_valid, 3'b001);
    chk("single_rsp_data", bus.rsp_data, 32'h4040_0000);
    repeat (4) step();

    // Accepts at relative cycles 0, 1, 3; responses at 4, 5, 7 with a held gap at 6.
    bus.req_valid = 3'b010; rand_ops(); d0 = fadd(bus.req_a[63:32], bus.req_b[63:32]); step();
    bus.req_valid = 3'b100; rand_ops(); d1 = fadd(bus.req_a[95:64], bus.req_b[95:64]); step();
    bus.req_valid = '0; step();
    bus.req_valid = 3'b001; rand_ops(); d3 = fadd(bus.req_a[31:0], bus.req_b[31:0]); step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("gap_rsp0_valid", bus.rsp_valid, 3'b010);
    chk("gap_rsp0_data", bus.rsp_data, d0);
    step();
    @(negedge clk);
    chk("gap_rsp1_valid", bus.rsp_valid, 3'b100);
    chk("gap_rsp1_data", bus.rsp_data, d1);
    step();
    @(negedge clk);
    chk("gap_idle_valid", bus.rsp_valid, 3'b000);
    chk("gap_idle_hold", bus.rsp_data, d1);
    step();
    @(negedge clk);
    chk("gap_rsp3_valid", bus.rsp_valid, 3'b001);
    chk("gap_rsp3_data", bus.rsp_data, d3);
    repeat (4) step();

    // Reset while requester 1's operation is in flight.
    bus.req_valid = 3'b010;
    bus.req_a[63:32] = 32'h3F80_0000;
    bus.req_b[63:32] = 32'h3F80_0000;
    @(negedge clk);
    chk("rstmid_ready", bus.req_ready, 3'b010);
    step();
    bus.req_valid = '0;
    step();
    step();
    rst_n = 1'b0;
    bus.req_valid = 3'b111;
    @(negedge clk);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_ready", bus.req_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_ptr0", bus.req_ready, 3'b001);
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid_no_stale_rsp", bus.rsp_valid[1], 0);
      step();
    end

`ifdef ARB_FIXED_PRIO_EN
    // Requester 0 keeps winning while requester 2 waits.
    bus.req_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      @(negedge clk);
      chk("fixed_prio_ready", bus.req_ready, 3'b001);
      step();
    end
    bus.req_valid = 3'b100;
    @(negedge clk);
    chk("fixed_prio_release", bus.req_ready, 3'b100);
    step();
    bus.req_valid = '0;
    repeat (6) step();
`endif

    for (int i = 0; i < 400; i++) begin
      bus.req_valid = N_REQ'($urandom);
      rand_ops();
      step();
    end
    bus.req_valid = '0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one fixed-latency floating-point functional unit (dp/add/exp/recip, externally instantiated) among N_REQ requesters.
- Round-robin grants one operation per cycle. Registers operands toward the unit and tracks each operation's owner through a LAT-deep tag pipeline.
- Steers each result back to the requester that issued it.
- Sits between the RNN layer sequencers and a single DW floating-point instance, replacing per-lane duplicated units.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- DATA_W, 32, operand/result width (IEEE single)
- LAT, 2, cycles from fu_in_valid high to fu_z valid (0..15; 0 = purely combinational unit)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operation request
- req_ready  out  N_REQ  one-hot grant, combinational
- req_a  in  N_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  N_REQ*DATA_W  operand B, same packing
- fu_in_valid  out  1  registered issue strobe to the unit
- fu_a  out  DATA_W  registered operand A to the unit
- fu_b  out  DATA_W  registered operand B to the unit
- fu_z  in  DATA_W  unit result, sampled LAT cycles after the fu_in_valid cycle
- rsp_valid  out  N_REQ  one-hot result strobe, registered
- rsp_data  out  DATA_W  result, registered, shared by all requesters
- busy  out  1  high while any operation is issued or in flight

Behaviour:
- Reset (async, rst_n low) clears the following to 0: fu_in_valid, fu_a, fu_b, rsp_valid, rsp_data, the RR pointer, and all tag-pipeline valids. busy reads 0 and req_ready reads 0 while rst_n is low. In-flight operations are discarded; no rsp_valid is produced for them after release.
- Arbitration:
  - Pointer ptr (clog2(N_REQ) bits).
  - Grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, ... mod N_REQ.
  - req_ready = grant one-hot. At most one bit is set; all bits are 0 if no req_valid.
  - Accept occurs when req_valid[i] & req_ready[i]. The requester holds operands stable only until accept.
  - On accept, ptr <= (i+1) mod N_REQ. With no accept, ptr holds.
- Issue: on the accept edge, fu_a/fu_b <= the winner's operands, fu_in_valid <= 1, tag stage 0 <= {1, i}. Without an accept, fu_in_valid <= 0 and fu_a/fu_b hold.
- Tag pipeline:
  - LAT+1 stages of {valid, owner} advance every cycle. There is no stall: the unit is fully pipelined or combinational.
  - Stage LAT aligns with fu_z.
  - When stage LAT is valid, at the next edge rsp_data <= fu_z and rsp_valid <= onehot(owner); otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: accept at edge k → fu_in_valid high in cycle k+1 → fu_z sampled in cycle k+1+LAT → rsp_valid high for exactly one cycle, cycle k+2+LAT.
- Throughput: one accept per cycle sustained. Responses return in accept order.
- busy = fu_in_valid | any tag stage valid | any rsp_valid.
- Simultaneous events: an accept, an in-flight advance and a response delivery in the same cycle are all legal and independent.
- A requester dropping req_valid before accept loses no state.
- Pointer wrap: ptr = N_REQ-1 with an accept moves to 0.
- Width rule: operands and results are passed bit-exact; no arithmetic in this block.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: ptr is removed; requester 0 has highest priority, then 1, and so on. Starvation of higher indices is permitted.
- Undefined: round-robin as specified above.
- Latency and response steering are identical in both builds.

Test Plan:
- Reset mid-flight (N_REQ=3, LAT=2): accept req 1 with a=0x3F800000, pull rst_n low 2 cycles later → no rsp_valid ever appears; busy=0; ptr=0 after release.
- Single request: req 0 with a=0x40000000, b=0x3F800000, fu_z model = a+b → fu_in_valid 1 cycle after accept; rsp_valid=3'b001 with rsp_data=0x40400000 at cycle accept+4.
- All three requesters valid continuously for 6 cycles from ptr=0 → grant order 0,1,2,0,1,2; one rsp per cycle in the same order; each rsp_data matches its own operands.
- Wrap/fairness: only req 2 and req 0 valid, ptr=1 → grant 2, then 0, then 2.
- Back-to-back with gap: accepts at cycles 5, 6, 8 → rsp_valid at 9, 10, 12; rsp_valid low at 11, rsp_data held at cycle-10 value.
- ARB_FIXED_PRIO_EN build: reqs 0 and 2 valid continuously → req 0 granted every cycle, req_ready[2] stays 0 until req 0 drops.
